// File: rtl/adder.sv
// Registered unsigned adder producing a WIDTH+1 bit sum (carry in the MSB) plus a valid flag.
// Define ADDER_IN_REG_EN to add an operand register stage (latency 2 instead of 1).
module adder #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic [WIDTH:0]   out_c,
    output logic             out_valid
);

    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic             opnd_valid;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH:0]   sum_q;
    logic             valid_q;

`ifdef ADDER_IN_REG_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             in_valid_q;

    // Operand stage clears on reset so no stale operand reaches the sum after release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            in_valid_q <= 1'b0;
        end else begin
            a_q        <= input_a;
            b_q        <= input_b;
            in_valid_q <= 1'b1;
        end
    end

    assign opnd_a     = a_q;
    assign opnd_b     = b_q;
    assign opnd_valid = in_valid_q;
`else
    assign opnd_a     = input_a;
    assign opnd_b     = input_b;
    assign opnd_valid = 1'b1;
`endif

    // Widen before adding so the carry lands in the extra bit instead of wrapping.
    always_comb begin
        sum_d = {1'b0, opnd_a} + {1'b0, opnd_b};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= opnd_valid;
        end
    end

    assign out_c     = sum_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed cases plus random operands against a history-based model.
// Works for both builds; the model latency follows ADDER_IN_REG_EN.
module tb_adder;

    localparam int W = 2;
`ifdef ADDER_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] input_a;
    logic [W-1:0] input_b;
    logic [W:0]   out_c;
    logic         out_valid;

    int n_vec = 0;
    int n_err = 0;

    // Per-posedge history of what the DUT saw: was reset released, and the operand sum.
    bit hist_ok[$];
    int hist_sum[$];

    adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .input_a   (input_a),
        .input_b   (input_b),
        .out_c     (out_c),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        hist_ok.push_back(rst_n === 1'b1);
        hist_sum.push_back(int'(input_a) + int'(input_b));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output is a real sum only when reset was released on each of the last LAT edges;
    // it is then the sum of operands seen LAT edges back, otherwise everything is zero.
    task automatic check_model(input string tag);
        int  n;
        bit  valid;
        int  exp_sum;
        n     = hist_ok.size();
        valid = (n >= LAT);
        for (int i = 0; i < LAT && valid; i++)
            if (!hist_ok[n-1-i]) valid = 1'b0;
        exp_sum = valid ? hist_sum[n-LAT] : 0;
        check({tag, "_sum"}, 64'(out_c), 64'(exp_sum));
        check({tag, "_valid"}, 64'(out_valid), 64'(valid));
    endtask

    // Drive at negedge (or time 0), let one posedge pass, then compare at the next negedge.
    task automatic cycle(input logic rst, input int a, input int b, input string tag);
        rst_n   = rst;
        input_a = W'(a);
        input_b = W'(b);
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        input_a = '0;
        input_b = '0;

        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 3, 3, "reset");
            check("reset_c_zero", 64'(out_c), 64'd0);
            check("reset_v_zero", 64'(out_valid), 64'd0);
        end

        cycle(1'b1, 1, 2, "basic");
        for (int i = 1; i < LAT; i++) cycle(1'b1, 1, 2, "basic_hold");
        check("basic_c_3", 64'(out_c), 64'd3);

        cycle(1'b1, 3, 3, "carry");
        for (int i = 1; i < LAT; i++) cycle(1'b1, 3, 3, "carry_hold");
        check("carry_c_6", 64'(out_c), 64'd6);
        check("carry_msb", 64'(out_c[W]), 64'd1);

        cycle(1'b1, 0, 0, "pipe0");
        cycle(1'b1, 1, 1, "pipe1");
        cycle(1'b1, 2, 3, "pipe2");
        cycle(1'b1, 3, 0, "pipe3");

        for (int i = 0; i < 3; i++) cycle(1'b1, 2, 2, "stream");
        cycle(1'b0, 2, 2, "midrst");
        check("midrst_c_zero", 64'(out_c), 64'd0);
        check("midrst_v_zero", 64'(out_valid), 64'd0);
        for (int i = 0; i < LAT; i++) cycle(1'b1, 2, 2, "release");
        check("release_c_4", 64'(out_c), 64'd4);
        check("release_v_1", 64'(out_valid), 64'd1);

        for (int i = 0; i < 100; i++)
            cycle(1'b1, int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, (1 << W) - 1)), "rand");

        for (int i = 0; i < 20; i++)
            cycle(($urandom_range(0, 4) != 0), int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, (1 << W) - 1)), "rand_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
